answer_entry_ctrl: RTL and testbench

- Parametrised successor to the 3-digit game input block for the factorization game.
- Handles N-digit answer entry, question capture/display, and answer submission under the top-level game STATE.
- Adds rising-edge button detection, configurable digit range, an entry FSM with lock-after-submit, and incomplete-answer rejection.
- Sits between the switch/button debouncers and the judge/score logic; drives the 7-seg digit muxes.

---
 rtl/answer_entry_ctrl_pkg.sv | 30 +++
 rtl/answer_entry_ctrl_btn_event.sv | 56 +++++
 rtl/answer_entry_ctrl.sv | 168 ++++++++++++++++
 tb/tb_answer_entry_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/answer_entry_ctrl_pkg.sv
// Shared game STATE encodings, entry FSM states and default STATE masks
// used by answer_entry_ctrl.
package game_state_pkg;

  localparam int GAME_STATE_W = 4;

  typedef enum logic [GAME_STATE_W-1:0] {
    ST_READY    = 4'd2,
    ST_QUESTION = 4'd3,
    ST_INPUT    = 4'd4,
    ST_DRAW     = 4'd6,
    ST_WRONG    = 4'd7,
    ST_GOOD     = 4'd8,
    ST_OUCH     = 4'd9,
    ST_WIN      = 4'd10,
    ST_LOSE     = 4'd11
  } game_state_e;

  // One bit per STATE value.
  localparam logic [15:0] DIG_CLR_MASK_DEF = 16'h0FC0;
  localparam logic [15:0] ANS_CLR_MASK_DEF = 16'h0180;
  localparam logic [15:0] QCAP_MASK_DEF    = 16'h0098;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    LOCKED = 2'd2
  } entry_st_e;

endpackage

// File: rtl/answer_entry_ctrl_btn_event.sv
// Rising-edge event for one debounced button; with ANSWER_ENTRY_AUTOREPEAT_EN
// defined, a held and enabled button also emits hold/repeat events.
module btn_event
`ifdef ANSWER_ENTRY_AUTOREPEAT_EN
#(
  parameter int HOLD_CYC = 25_000_000,
  parameter int RPT_CYC  = 5_000_000
)
`endif
(
  input  logic CLK,
  input  logic RST,
  input  logic btn_i,
  input  logic rpt_en_i,
  output logic evt_o
);

  logic prev_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) prev_q <= 1'b0;
    else     prev_q <= btn_i;
  end

`ifdef ANSWER_ENTRY_AUTOREPEAT_EN
  logic [31:0] cnt_q;
  logic        rpt_q;
  logic        held, fire;

  // rpt_q marks that the initial hold period has elapsed.
  assign held = btn_i & rpt_en_i;
  assign fire = held && (cnt_q == (rpt_q ? 32'(RPT_CYC - 1) : 32'(HOLD_CYC - 1)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      rpt_q <= 1'b0;
    end else if (!held) begin
      cnt_q <= '0;
      rpt_q <= 1'b0;
    end else if (fire) begin
      cnt_q <= '0;
      rpt_q <= 1'b1;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign evt_o = (btn_i & ~prev_q) | fire;
`else
  logic unused_rpt_en;
  assign unused_rpt_en = rpt_en_i;
  assign evt_o = btn_i & ~prev_q;
`endif

endmodule

// File: rtl/answer_entry_ctrl.sv
// N-digit answer entry, question capture/display and answer submission.
// Optional auto-repeat of digit buttons: ANSWER_ENTRY_AUTOREPEAT_EN.
module answer_entry_ctrl
  import game_state_pkg::*;
#(
  parameter int N_DIGITS  = 3,
  parameter int DIGIT_W   = 4,
  parameter int DIGIT_MIN = 1,
  parameter int DIGIT_MAX = 9,
  parameter int STATE_W   = GAME_STATE_W,
  parameter logic [2**STATE_W-1:0] DIG_CLR_MASK = DIG_CLR_MASK_DEF,
  parameter logic [2**STATE_W-1:0] ANS_CLR_MASK = ANS_CLR_MASK_DEF,
  parameter logic [2**STATE_W-1:0] QCAP_MASK    = QCAP_MASK_DEF
`ifdef ANSWER_ENTRY_AUTOREPEAT_EN
  ,
  parameter int HOLD_CYC = 25_000_000,
  parameter int RPT_CYC  = 5_000_000
`endif
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [STATE_W-1:0]              STATE,
  input  logic [2*N_DIGITS*DIGIT_W-1:0]   QUESTION,
  input  logic [N_DIGITS-1:0]             SEL,
  input  logic                            DEC,
  input  logic                            CLR,
  output logic [N_DIGITS*DIGIT_W-1:0]     DIG_DISP,
  output logic [N_DIGITS*DIGIT_W-1:0]     Q_DISP,
  output logic [N_DIGITS*DIGIT_W-1:0]     ANS,
  output logic                            ANS_VALID,
  output logic                            ANS_ERR,
  output logic                            QUE_OK,
  output logic                            LED
);

  localparam int DW = N_DIGITS * DIGIT_W;
  localparam int NB = N_DIGITS + 2;

  logic [NB-1:0] btn, rpt_en, evt;
  logic [N_DIGITS-1:0] sel_ev;
  logic dec_ev, clr_ev;

  assign btn = {CLR, DEC, SEL};

`ifdef ANSWER_ENTRY_AUTOREPEAT_EN
  // Only the lowest-index held digit button may auto-repeat.
  always_comb begin
    logic found;
    rpt_en = '0;
    found  = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (SEL[i] && !found) begin
        rpt_en[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end
`else
  assign rpt_en = '0;
`endif

  for (genvar g = 0; g < NB; g++) begin : g_btn
    btn_event
`ifdef ANSWER_ENTRY_AUTOREPEAT_EN
      #(.HOLD_CYC(HOLD_CYC), .RPT_CYC(RPT_CYC))
`endif
      u_btn (
        .CLK      (CLK),
        .RST      (RST),
        .btn_i    (btn[g]),
        .rpt_en_i (rpt_en[g]),
        .evt_o    (evt[g])
      );
  end

  assign sel_ev = evt[N_DIGITS-1:0];
  assign dec_ev = evt[N_DIGITS];
  assign clr_ev = evt[N_DIGITS+1];

  entry_st_e st_q, st_d;
  logic [N_DIGITS-1:0][DIGIT_W-1:0] dig_q, dig_d, ans_q, ans_d;
  logic valid_q, valid_d, err_q, err_d;
  logic in_input, all_set, hit;
  logic [DW-1:0] q_q, q_d, qdisp_q, dig_disp_q;
  logic que_ok_q, led_q;

  assign in_input = (STATE == STATE_W'(ST_INPUT));

  always_comb begin
    st_d    = st_q;
    dig_d   = dig_q;
    ans_d   = ans_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    hit     = 1'b0;
    all_set = 1'b1;
    for (int i = 0; i < N_DIGITS; i++)
      if (dig_q[i] == '0) all_set = 1'b0;
    case (st_q)
      IDLE: if (in_input) st_d = EDIT;
      EDIT: begin
        if (!in_input) st_d = IDLE;
        else if (clr_ev) dig_d = '0;
        else begin
          for (int i = 0; i < N_DIGITS; i++) begin
            if (sel_ev[i] && !hit) begin
              hit      = 1'b1;
              dig_d[i] = (dig_q[i] >= DIGIT_W'(DIGIT_MAX)) ? DIGIT_W'(DIGIT_MIN)
                                                           : dig_q[i] + DIGIT_W'(1);
            end
          end
          // Submit judges the digits as they stood before any same-cycle increment.
          if (dec_ev) begin
            if (all_set) begin
              ans_d   = dig_q;
              valid_d = 1'b1;
              st_d    = LOCKED;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      LOCKED:  if (!in_input) st_d = IDLE;
      default: st_d = IDLE;
    endcase
    if (DIG_CLR_MASK[STATE]) dig_d = '0;
    if (ANS_CLR_MASK[STATE]) ans_d = '0;
  end

  assign q_d = (QCAP_MASK[STATE] || (STATE == STATE_W'(ST_READY) && QUESTION != '0))
               ? QUESTION[2*DW-1 -: DW] : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_q       <= IDLE;
      dig_q      <= '0;
      ans_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      q_q        <= '0;
      qdisp_q    <= '0;
      que_ok_q   <= 1'b0;
      led_q      <= 1'b0;
      dig_disp_q <= '0;
    end else begin
      st_q       <= st_d;
      dig_q      <= dig_d;
      ans_q      <= ans_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      q_q        <= q_d;
      qdisp_q    <= (STATE == STATE_W'(ST_QUESTION)) ? q_q : '0;
      que_ok_q   <= (q_q != '0);
      led_q      <= que_ok_q;
      dig_disp_q <= in_input ? dig_q : '0;
    end
  end

  assign DIG_DISP  = dig_disp_q;
  assign Q_DISP    = qdisp_q;
  assign ANS       = ans_q;
  assign ANS_VALID = valid_q;
  assign ANS_ERR   = err_q;
  assign QUE_OK    = que_ok_q;
  assign LED       = led_q;

endmodule

// File: tb/tb_answer_entry_ctrl.sv
// Directed bench for answer_entry_ctrl; submit pulses are checked by a
// scoreboard monitor, levels by direct comparisons.
module tb_answer_entry_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  STATE = 4'd0;
  logic [23:0] QUESTION = 24'h0;
  logic [2:0]  SEL = 3'b000;
  logic        DEC = 1'b0;
  logic        CLR = 1'b0;
  logic [11:0] DIG_DISP, Q_DISP, ANS;
  logic        ANS_VALID, ANS_ERR, QUE_OK, LED;

  typedef struct packed {
    logic        err;
    logic [11:0] ans;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   seq[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 1};

  always #5 CLK = ~CLK;

  answer_entry_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .STATE     (STATE),
    .QUESTION  (QUESTION),
    .SEL       (SEL),
    .DEC       (DEC),
    .CLR       (CLR),
    .DIG_DISP  (DIG_DISP),
    .Q_DISP    (Q_DISP),
    .ANS       (ANS),
    .ANS_VALID (ANS_VALID),
    .ANS_ERR   (ANS_ERR),
    .QUE_OK    (QUE_OK),
    .LED       (LED)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic press(input logic [2:0] s, input logic d, input logic c);
    SEL = s; DEC = d; CLR = c;
    tick();
    SEL = 3'b000; DEC = 1'b0; CLR = 1'b0;
    tick();
  endtask

  task automatic push(input logic err, input logic [11:0] ans);
    exp_t e;
    e.err = err;
    e.ans = ans;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST && (ANS_VALID || ANS_ERR)) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_pulse: valid=%b err=%b ans=%h, no pulse expected",
                   ANS_VALID, ANS_ERR, ANS);
        end else begin
          e = sb.pop_front();
          check("pulse_kind", 32'({ANS_ERR, ANS_VALID}), e.err ? 32'd2 : 32'd1);
          check("pulse_ans", 32'(ANS), 32'(e.ans));
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    fork
      monitor();
    join_none
    tick(); tick();

    check("rst_dig_disp", 32'(DIG_DISP), 32'h0);
    check("rst_q_disp",   32'(Q_DISP),   32'h0);
    check("rst_ans",      32'(ANS),      32'h0);
    check("rst_valid",    32'(ANS_VALID), 32'h0);
    check("rst_err",      32'(ANS_ERR),  32'h0);
    check("rst_que_ok",   32'(QUE_OK),   32'h0);
    check("rst_led",      32'(LED),      32'h0);
    RST = 1'b0;
    tick();

    // Digit stepping and wrap.
    STATE = 4'd4;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      press(3'b001, 1'b0, 1'b0);
      check("digit0_step", 32'(DIG_DISP), 32'(seq[i]));
    end

    // Held button gives one event.
    SEL = 3'b001;
    repeat (50) tick();
    SEL = 3'b000;
    tick();
    check("hold_single", 32'(DIG_DISP), 32'h002);

    press(3'b101, 1'b0, 1'b0);
    check("lowest_sel", 32'(DIG_DISP), 32'h003);
    press(3'b010, 1'b0, 1'b1);
    check("clr_priority", 32'(DIG_DISP), 32'h000);

    // Incomplete answer rejected.
    repeat (3) press(3'b001, 1'b0, 1'b0);
    repeat (5) press(3'b100, 1'b0, 1'b0);
    check("digits_305", 32'(DIG_DISP), 32'h503);
    push(1'b1, 12'h000);
    press(3'b000, 1'b1, 1'b0);
    check("err_ans_kept", 32'(ANS), 32'h000);

    // Complete answer accepted, then locked.
    repeat (2) press(3'b010, 1'b0, 1'b0);
    check("digits_325", 32'(DIG_DISP), 32'h523);
    push(1'b0, 12'h523);
    press(3'b000, 1'b1, 1'b0);
    check("ans_523", 32'(ANS), 32'h523);
    press(3'b001, 1'b0, 1'b0);
    press(3'b000, 1'b1, 1'b0);
    press(3'b000, 1'b0, 1'b1);
    check("locked_digits", 32'(DIG_DISP), 32'h523);
    check("locked_ans", 32'(ANS), 32'h523);

    // STATE 6 clears digits only; STATE 7 clears answer too.
    STATE = 4'd6;
    tick(); tick();
    check("s6_ans_kept", 32'(ANS), 32'h523);
    STATE = 4'd4;
    tick(); tick();
    check("s6_digits_clr", 32'(DIG_DISP), 32'h000);
    press(3'b001, 1'b0, 1'b0);
    check("reentry_edit", 32'(DIG_DISP), 32'h001);
    STATE = 4'd7;
    tick();
    check("s7_ans_clr", 32'(ANS), 32'h000);
    STATE = 4'd4;
    tick(); tick();
    check("s7_digits_clr", 32'(DIG_DISP), 32'h000);

    // Question path latencies.
    STATE = 4'd2;
    QUESTION = 24'h123000;
    tick();
    check("que_ok_lat1", 32'(QUE_OK), 32'h0);
    tick();
    check("que_ok_lat2", 32'(QUE_OK), 32'h1);
    check("led_lat2", 32'(LED), 32'h0);
    tick();
    check("led_lat3", 32'(LED), 32'h1);
    STATE = 4'd3;
    tick();
    check("q_disp", 32'(Q_DISP), 32'h123);
    STATE = 4'd2;
    QUESTION = 24'h0;
    tick(); tick();
    check("que_ok_zero", 32'(QUE_OK), 32'h0);
    check("q_disp_off", 32'(Q_DISP), 32'h000);

    // Asynchronous reset mid-game.
    STATE = 4'd4;
    QUESTION = 24'h456000;
    tick(); tick();
    for (int d = 0; d < 3; d++)
      repeat (4) press(3'(1 << d), 1'b0, 1'b0);
    check("digits_444", 32'(DIG_DISP), 32'h444);
    push(1'b0, 12'h444);
    press(3'b000, 1'b1, 1'b0);
    check("ans_444", 32'(ANS), 32'h444);
    check("que_ok_s4", 32'(QUE_OK), 32'h1);
    check("led_s4", 32'(LED), 32'h1);
    RST = 1'b1;
    #1;
    check("arst_dig_disp", 32'(DIG_DISP), 32'h0);
    check("arst_ans",      32'(ANS),      32'h0);
    check("arst_que_ok",   32'(QUE_OK),   32'h0);
    check("arst_led",      32'(LED),      32'h0);
    QUESTION = 24'h0;
    tick(); tick();
    RST = 1'b0;
    tick(); tick();
    check("post_rst_digits", 32'(DIG_DISP), 32'h000);
    press(3'b100, 1'b0, 1'b0);
    check("post_rst_edit", 32'(DIG_DISP), 32'h100);

    tick(); tick();
    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
